// File: rtl/fp_mul_normalizer.sv
// Normalise/round stage of the binary32 multiplier: iterative one-shift-per-cycle
// normalisation with gradual underflow, RNE rounding. Define FP_MUL_FTZ_EN to flush tiny results to zero.
module fp_mul_normalizer #(
    parameter int EXP_W      = 10,
    parameter int MANT_W     = 48,
    parameter int TINY_LIMIT = -30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_nan,
    input  logic              in_inf,
    input  logic              in_zero,
    output logic [31:0]       res,
    output logic              done,
    output logic              busy,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact,
    output logic [1:0]        state_dbg
);

    // Handshake: ready is a one-cycle start strobe honoured only while busy=0;
    // done is a one-cycle pulse with res/flags registered on the same edge and
    // held until the next done. busy drops on the edge that raises done.

    // Two guard bits keep in_exp+1 and the rounding carry from wrapping.
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic signed [XW-1:0] EMAX = XW'(255);
    localparam logic signed [XW-1:0] TINY = XW'(TINY_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [MANT_W-1:0]      w_q, w_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    logic                   sticky_q, sticky_d;
    logic                   sign_q, sign_d;
    logic                   spec_q, spec_d;
    logic [31:0]            spec_res_q, spec_res_d;
    logic [31:0]            res_d;
    logic                   done_d, busy_d, ovf_d, unf_d, inex_d;

    logic [MANT_W-1:0]      cap_w;
    logic                   cap_sticky;
    logic signed [XW-1:0]   cap_exp;

    logic                   rnd_g, rnd_rs, rnd_inc, rnd_hid;
    logic [24:0]            rnd_sum;
    logic signed [XW-1:0]   rnd_exp;
    logic [22:0]            rnd_frac;
    logic [7:0]             rnd_field;

    assign state_dbg = state_q;

    always_comb begin
        cap_w      = in_mant;
        cap_sticky = 1'b0;
        cap_exp    = {{2{in_exp[EXP_W-1]}}, in_exp};
        if (in_mant[MANT_W-1]) begin
            cap_w      = in_mant >> 1;
            cap_sticky = in_mant[0];
            cap_exp    = cap_exp + ONE;
        end
        // Far too small to reach even the lowest subnormal: keep only stickiness.
        if (cap_exp < TINY) begin
            cap_w      = '0;
            cap_sticky = |in_mant;
            cap_exp    = ONE;
        end
    end

    always_comb begin
        rnd_g     = w_q[22];
        rnd_rs    = (|w_q[21:0]) | sticky_q;
        rnd_inc   = rnd_g & (rnd_rs | w_q[23]);
        rnd_sum   = {1'b0, w_q[46:23]} + {24'b0, rnd_inc};
        rnd_exp   = rnd_sum[24] ? exp_q + ONE : exp_q;
        rnd_frac  = rnd_sum[24] ? 23'd0 : rnd_sum[22:0];
        rnd_hid   = rnd_sum[24] | rnd_sum[23];
        rnd_field = rnd_hid ? rnd_exp[7:0] : 8'd0;
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        exp_d      = exp_q;
        sticky_d   = sticky_q;
        sign_d     = sign_q;
        spec_d     = 1'b0;
        spec_res_d = spec_res_q;
        res_d      = res;
        done_d     = 1'b0;
        busy_d     = busy;
        ovf_d      = overflow;
        unf_d      = underflow;
        inex_d     = inexact;

        case (state_q)
            IDLE: begin
                if (spec_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    res_d  = spec_res_q;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    inex_d = 1'b0;
                end else if (ready) begin
                    busy_d = 1'b1;
                    sign_d = in_sign;
                    if (in_nan) begin
                        spec_d     = 1'b1;
                        spec_res_d = 32'h7FC0_0000;
                    end else if (in_inf) begin
                        spec_d     = 1'b1;
                        spec_res_d = {in_sign, 8'hFF, 23'd0};
                    end else if (in_zero) begin
                        spec_d     = 1'b1;
                        spec_res_d = {in_sign, 31'd0};
                    end else begin
                        w_d      = cap_w;
                        exp_d    = cap_exp;
                        sticky_d = cap_sticky;
                        state_d  = NORM;
                    end
                end
            end
            NORM: begin
                if ((w_q == '0) && !sticky_q) begin
                    state_d = ROUND;
                end else if (exp_q < ONE) begin
`ifdef FP_MUL_FTZ_EN
                    state_d = ROUND;
`else
                    w_d      = w_q >> 1;
                    sticky_d = sticky_q | w_q[0];
                    exp_d    = exp_q + ONE;
`endif
                end else if (!w_q[46] && (exp_q > ONE) && (w_q != '0)) begin
                    w_d   = w_q << 1;
                    exp_d = exp_q - ONE;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef FP_MUL_FTZ_EN
                if (exp_q < ONE) begin
                    res_d  = {sign_q, 31'd0};
                    ovf_d  = 1'b0;
                    unf_d  = 1'b1;
                    inex_d = (w_q != '0) | sticky_q;
                end else
`endif
                if (rnd_exp >= EMAX) begin
                    res_d  = {sign_q, 8'hFF, 23'd0};
                    ovf_d  = 1'b1;
                    inex_d = 1'b1;
                    unf_d  = ~w_q[46];
                end else begin
                    res_d  = {sign_q, rnd_field, rnd_frac};
                    ovf_d  = 1'b0;
                    inex_d = rnd_g | rnd_rs;
                    unf_d  = (rnd_g | rnd_rs) & ~w_q[46];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= '0;
            exp_q      <= '0;
            sticky_q   <= 1'b0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
            res        <= 32'd0;
            done       <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            inexact    <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            exp_q      <= exp_d;
            sticky_q   <= sticky_d;
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            res        <= res_d;
            done       <= done_d;
            busy       <= busy_d;
            overflow   <= ovf_d;
            underflow  <= unf_d;
            inexact    <= inex_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_normalizer.sv
// Scoreboard bench for fp_mul_normalizer: directed IEEE cases, random exact
// products, busy-time ready, mid-operation reset. Expectations follow FP_MUL_FTZ_EN.
module tb_fp_mul_normalizer;

    localparam int W = 35;  // {res, overflow, underflow, inexact}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_zero = 1'b0;
    logic [31:0] res;
    logic        done, busy, overflow, underflow, inexact;
    logic [1:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           st_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int pushed = 0;
    int spurious = 0;

    fp_mul_normalizer dut (
        .clk(clk), .rst(rst), .ready(ready), .in_sign(in_sign), .in_exp(in_exp),
        .in_mant(in_mant), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .res(res), .done(done), .busy(busy), .overflow(overflow),
        .underflow(underflow), .inexact(inexact), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // driver
    task automatic send(input logic sgn, input logic [9:0] e, input logic [47:0] m,
                        input logic nan, input logic inf, input logic zero,
                        input logic [W-1:0] expv, input int lat, input bit push);
        @(negedge clk);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        in_sign = sgn; in_exp = e; in_mant = m;
        in_nan = nan; in_inf = inf; in_zero = zero;
        ready = 1'b1;
        if (push) begin
            exp_q.push_back(expv);
            lat_q.push_back(lat);
            pushed++;
        end
        @(posedge clk);
        #1;
        if (push) st_q.push_back(cyc);
        ready = 1'b0;
    endtask

    task automatic norm(input logic sgn, input logic [9:0] e, input logic [47:0] m,
                        input logic [31:0] r, input logic [2:0] fl, input int lat);
        send(sgn, e, m, 1'b0, 1'b0, 1'b0, {r, fl}, lat, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                spurious++;
            end else begin
                logic [W-1:0] v;
                int l, s;
                v = exp_q.pop_front();
                l = lat_q.pop_front();
                s = (st_q.size() != 0) ? st_q.pop_front() : 0;
                check("res", res, v[34:3]);
                check("overflow", overflow, v[2]);
                check("underflow", underflow, v[1]);
                check("inexact", inexact, v[0]);
                check("latency", cyc - s, l);
            end
        end
    end

    initial begin
        logic [22:0] fr;
        logic [9:0]  e;
        logic        sg;
        repeat (3) @(negedge clk);
        check("rst_res", res, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {overflow, underflow, inexact}, 0);
        rst = 1'b0;

        norm(0, 10'd127, 48'h9000_0000_0000, 32'h4010_0000, 3'b000, 2);
        norm(0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001, 2);
        norm(0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001, 2);
        norm(1, 10'd300, 48'h4000_0000_0000, 32'hFF80_0000, 3'b101, 2);
        norm(0, 10'd254, 48'h4000_0000_0000, 32'h7F00_0000, 3'b000, 2);
        norm(0, 10'd255, 48'h4000_0000_0000, 32'h7F80_0000, 3'b101, 2);
        norm(0, 10'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 3'b001, 2);
        norm(0, 10'd127, 48'h8000_0000_0001, 32'h4000_0000, 3'b001, 2);
        norm(1, 10'd127, 48'h0000_0000_0000, 32'h8000_0000, 3'b000, 2);
        norm(0, -10'sd40, 48'h4000_0000_0000, 32'h0000_0000, 3'b011, 2);
`ifdef FP_MUL_FTZ_EN
        norm(0, -10'sd1, 48'h4000_0000_0000, 32'h0000_0000, 3'b011, 2);
        norm(1, 10'd0, 48'h7FFF_FF80_0000, 32'h8000_0000, 3'b011, 2);
`else
        norm(0, -10'sd1, 48'h4000_0000_0000, 32'h0020_0000, 3'b000, 4);
        norm(1, 10'd0, 48'h7FFF_FF80_0000, 32'h8080_0000, 3'b011, 3);
`endif
        send(0, 10'd5, 48'h4000_0000_0000, 1, 1, 1, {32'h7FC0_0000, 3'b000}, 1, 1'b1);
        send(1, 10'd5, 48'h4000_0000_0000, 0, 1, 1, {32'hFF80_0000, 3'b000}, 1, 1'b1);
        send(1, 10'd5, 48'h4000_0000_0000, 0, 0, 1, {32'h8000_0000, 3'b000}, 1, 1'b1);

        // random exactly representable products, with and without bit 47 set
        for (int i = 0; i < 8; i++) begin
            fr = 23'($urandom);
            sg = 1'($urandom_range(0, 1));
            e  = 10'($urandom_range(1, 253));
            if (i[0]) norm(sg, e, {1'b1, fr, 24'd0}, {sg, 8'(e + 10'd1), fr}, 3'b000, 2);
            else      norm(sg, e, {2'b01, fr, 23'd0}, {sg, e[7:0], fr}, 3'b000, 2);
        end
        drain();

        // slow case; a ready during busy must be ignored and inputs not re-sampled
        norm(0, 10'd127, 48'h0000_0080_0000, 32'h3400_0000, 3'b000, 25);
        check("busy_after_capture", busy, 1);
        repeat (3) @(negedge clk);
        in_nan = 1'b1; in_mant = 48'h9000_0000_0000; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0; in_nan = 1'b0;
        drain();

        // reset in the middle of normalisation aborts without a done
        send(0, 10'd127, 48'h0000_0080_0000, 0, 0, 0, '0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_res", res, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_state", state_dbg, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        norm(0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 3'b000, 2);
        drain();

        check("spurious_dones", spurious, 0);
        check("done_count", done_cnt, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_mul_normalizer.md
Name: fp_mul_normalizer

Overview:
Downstream stage of the single-precision multiplier datapath. Consumes the raw product (sign, unbiased-sum exponent, 48-bit significand product, special-case flags) and produces a packed IEEE754 binary32 result. Normalises iteratively, one shift per cycle, handling subnormal results. Rounds to nearest, ties to even. Uses the same ready/done pulse handshake as the multiplier core.

Parameters:
EXP_W, 10, width of two's-complement working exponent (covers -512..511)
MANT_W, 48, width of significand product input (24x24 with hidden bits)
TINY_LIMIT, -30, capture-time exponent below which the result collapses straight to sticky-only

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
ready  input  1  one-cycle start strobe; sampled only when busy=0
in_sign  input  1  product sign (op1 sign XOR op2 sign)
in_exp  input  EXP_W  biased product exponent e1+e2-127, two's complement
in_mant  input  MANT_W  significand product; binary point between bits 46 and 45
in_nan  input  1  upstream detected NaN operand or 0*inf
in_inf  input  1  upstream detected infinite result
in_zero  input  1  upstream detected zero operand
res  output  32  packed binary32 result; held until next done
done  output  1  one-cycle pulse, res/flags valid
busy  output  1  high from capture until the cycle done is asserted
overflow  output  1  result overflowed to infinity (valid with done, held)
underflow  output  1  result tiny and inexact (valid with done, held)
inexact  output  1  rounding discarded nonzero bits (valid with done, held)

Behaviour:
- Reset: res=0, done=0, busy=0, overflow=underflow=inexact=0, FSM=IDLE. Reset mid-operation aborts; no done is issued.
- FSM states: IDLE, NORM, ROUND. done is a registered pulse; res and flags are registered at the same edge.
- IDLE, ready=1 at edge N:
  - Specials are checked in priority nan > inf > zero.
    - nan: res=0x7FC00000.
    - inf: res={sign,0xFF,0}.
    - zero: res={sign,0}.
  - For any special, all flags are 0, done=1 after edge N+1, and the FSM stays in IDLE with busy high for that one cycle.
  - Otherwise capture into working w[47:0], exp, sticky=0, then go to NORM.
    - If in_mant[47]=1: w=in_mant>>1, sticky=in_mant[0], exp=in_exp+1.
    - If exp < TINY_LIMIT after this: w=0, sticky=|in_mant, exp=1.
- NORM, one action per edge:
  - exp<1: w>>=1, sticky|=shifted-out bit, exp+=1.
  - else if w[46]=0 and exp>1 and w!=0: w<<=1, exp-=1.
  - else: go to ROUND.
- ROUND at edge:
  - G=w[22], RS=|w[21:0] | sticky, lsb=w[23].
  - Increment the {w[46],w[45:23]} field if G & (RS | lsb).
  - Carry out of bit 46 gives exp+1 and fraction 0.
  - Biased field = exp if the rounded hidden bit is 1, else 0 (subnormal/zero).
  - exp>=255 after rounding: res={sign,0xFF,0}, overflow=1, inexact=1.
  - inexact=G|RS; underflow=inexact & (pre-round hidden bit = 0).
  - done=1, busy=0 next cycle, return to IDLE.
- Latency: done high after edge N+2+nL+nR (nL left shifts, nR right shifts). Normal operands give 2 cycles. Specials give 1 cycle.
- ready while busy=1 is ignored; inputs are not re-sampled.
- ready coincident with done: accepted, because busy is already 0 in that cycle.
- w=0 with sticky=0 in NORM: go directly to ROUND, producing signed zero.

Optional Feature:
FP_MUL_FTZ_EN:
- Defined: in NORM, exp<1 does no right shifts. The result becomes signed zero {sign,31'b0} with underflow=1 and inexact=|w|sticky. This bounds latency to 2+nL.
- Undefined: full gradual-underflow behaviour as above.

Test Plan:
- in_exp=127, in_mant=0x900000000000 (1.5*1.5), ready pulse -> res=0x40100000, done after 2 cycles, all flags 0.
- in_exp=127, in_mant=0x400000C00000 -> res=0x3F800002, inexact=1. With in_mant=0x400000400000 (tie, lsb 0) -> res=0x3F800000, inexact=1.
- in_exp=300, in_mant=0x400000000000, in_sign=1 -> res=0xFF800000, overflow=1, inexact=1.
- in_exp=-1, in_mant=0x400000000000 -> res=0x00200000, done after 4 cycles, underflow=0. With FP_MUL_FTZ_EN -> res=0x00000000, underflow=1.
- in_nan=1 with ready -> res=0x7FC00000, done after 1 cycle. A second ready while busy (slow case in_mant=0x000000800000) is ignored; only one done is issued.
- Start the slow case above, assert rst mid-NORM -> all outputs 0, no done. Next ready with the 1.0*1.0 operands (in_exp=127, in_mant=0x400000000000) -> res=0x3F800000.
